// File: rtl/rr_trace_readonly_fetch_if.sv
// PCIM AXI bus subset for the replay fetch path.
// Only AR/R carry traffic; the master holds AW/W idle and B ready.
// Ports (master = fetch engine):
//   out: araddr arlen arsize arid arvalid rready awvalid wvalid bready
//   in:  arready rdata rresp rid rlast rvalid
interface rr_trace_readonly_fetch_if #(
  parameter int AW = 64,
  parameter int DW = 512
);
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [15:0]   arid;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [15:0]   rid;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic          awvalid;
  logic          wvalid;
  logic          bready;

  modport master (
    output araddr, arlen, arsize, arid, arvalid,
    output rready, awvalid, wvalid, bready,
    input  arready, rdata, rresp, rid, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arid, arvalid,
    input  rready, awvalid, wvalid, bready,
    output arready, rdata, rresp, rid, rlast, rvalid
  );
endinterface

// File: rtl/rr_trace_readonly_fetch.sv
// Replay trace fetch: reads a host buffer beat by beat over AXI AR/R,
// buffers it in a FWFT FIFO and streams it out; irq when fully drained.
// Ports: clk, rstn (async low), axi_in (master), read_buf_addr/size/update,
//   read_interrupt, replay_dout/_valid/_ready, replay_bytes, rresp_error.
// Option: RR_TRACE_READ_CHECK_EN adds sticky protocol checks + beat trace.
module rr_trace_readonly_fetch #(
  parameter int AXI_WIDTH       = 512,
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int FIFO_DEPTH      = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  rr_trace_readonly_fetch_if.master axi_in,
  input  logic [AXI_ADDR_WIDTH-1:0] read_buf_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] read_buf_size,
  input  logic                      read_buf_update,
  output logic                      read_interrupt,
  output logic [AXI_WIDTH-1:0]      replay_dout,
  output logic                      replay_dout_valid,
  input  logic                      replay_dout_ready,
  output logic [63:0]               replay_bytes,
  output logic                      rresp_error
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT =
    AXI_ADDR_WIDTH'(AXI_WIDTH / 8);
  localparam logic [63:0] BEAT64 = 64'(AXI_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] r_curr;
  logic [AXI_ADDR_WIDTH-1:0] r_end;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic                      r_arvalid;
  logic [OW-1:0]             r_out;
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [CW-1:0]             r_cnt;
  logic [AXI_WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [63:0]               r_bytes;
  logic                      r_rresp_err;

  logic w_load;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_empty;
  logic w_pop;
  logic w_credit;
  logic w_more;
  logic w_issue;

  assign w_load  = read_buf_update &
                   ((r_state == IDLE) | (r_state == DONE));
  assign w_ar_hs = r_arvalid & axi_in.arready;
  // Beats with nothing outstanding are stale (e.g. across a reset).
  assign w_r_hs  = axi_in.rvalid & (r_out != '0);
  assign w_empty = (r_cnt == '0);
  assign w_pop   = ~w_empty & replay_dout_ready;
  assign w_more  = r_curr < r_end;
  // Every request reserves a FIFO slot, so R beats never overflow.
  assign w_credit =
    ((32'(r_out) + 32'(r_cnt)) < 32'(FIFO_DEPTH)) &&
    (32'(r_out) < 32'(MAX_OUTSTANDING));
  assign w_issue = (r_state == FETCH) & ~r_arvalid & w_more & w_credit;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (read_buf_update)
          w_state_nxt = (read_buf_size == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (~w_more & ~r_arvalid)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((r_out == '0) && w_empty)
          w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_curr      <= '0;
      r_end       <= '0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_out       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_bytes     <= '0;
      r_rresp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_curr <= read_buf_addr;
        r_end  <= read_buf_addr + read_buf_size;
      end else if (w_ar_hs) begin
        r_curr <= r_curr + BEAT;
      end
      if (w_issue) begin
        r_arvalid <= 1'b1;
        r_araddr  <= r_curr;
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end
      unique case ({w_ar_hs, w_r_hs})
        2'b10:   r_out <= r_out + OW'(1);
        2'b01:   r_out <= r_out - OW'(1);
        default: r_out <= r_out;
      endcase
      unique case ({w_r_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_r_hs)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      if (w_load)
        r_bytes <= '0;
      else if (w_pop)
        r_bytes <= r_bytes + BEAT64;
      if (axi_in.rvalid && (axi_in.rresp != 2'b00))
        r_rresp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_r_hs)
      r_mem[r_wptr] <= axi_in.rdata;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn)
      assert (!(w_r_hs && (r_cnt == CW'(FIFO_DEPTH))))
        else $error("rr_trace fetch: read fifo overflow");
  end
`endif

  assign axi_in.araddr  = r_araddr;
  assign axi_in.arlen   = 8'd0;
  assign axi_in.arsize  = 3'b110;
  assign axi_in.arid    = '0;
  assign axi_in.arvalid = r_arvalid;
  assign axi_in.rready  = 1'b1;
  assign axi_in.awvalid = 1'b0;
  assign axi_in.wvalid  = 1'b0;
  assign axi_in.bready  = 1'b1;

  assign read_interrupt    = (r_state == DONE);
  assign replay_dout_valid = ~w_empty;
  assign replay_dout       = w_empty ? '0 : r_mem[r_rptr];
  assign replay_bytes      = r_bytes;

`ifdef RR_TRACE_READ_CHECK_EN
  logic                      r_proto_err;
  logic [AXI_ADDR_WIDTH-1:0] r_raddr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_proto_err <= 1'b0;
      r_raddr     <= '0;
    end else begin
      if (axi_in.rvalid &&
          (!axi_in.rlast || (axi_in.rid != '0) || (r_out == '0)))
        r_proto_err <= 1'b1;
      if (w_load)
        r_raddr <= read_buf_addr;
      else if (w_r_hs)
        r_raddr <= r_raddr + BEAT;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rstn && w_r_hs)
      $display("rr_trace fetch addr=%h data=%h", r_raddr, axi_in.rdata);
  end
`endif

  assign rresp_error = r_rresp_err | r_proto_err;
`else
  logic w_unused;
  assign w_unused    = ^{axi_in.rid, axi_in.rlast};
  assign rresp_error = r_rresp_err;
`endif
endmodule
